// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES widths, state/column types and GF(2^8) xtime helper
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_NB      = 4;

    typedef logic [7:0]             aes_byte_t;
    typedef logic [31:0]            aes_col_t;
    typedef logic [AES_STATE_W-1:0] aes_state_t;

    // Multiply by x (0x02) in GF(2^8) modulo x^8+x^4+x^3+x+1
    function automatic aes_byte_t xtime(input aes_byte_t b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// rtl/mix_column_word.sv - combinational MixColumns / InvMixColumns on one 32-bit column
module mix_column_word
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    input  logic        inv,
    output logic [31:0] col_out
);

    // Per-byte multiples built once from a shared xtime chain and reused by both directions
    aes_byte_t a   [AES_NB];
    aes_byte_t m2  [AES_NB];
    aes_byte_t m3  [AES_NB];
    aes_byte_t m9  [AES_NB];
    aes_byte_t m11 [AES_NB];
    aes_byte_t m13 [AES_NB];
    aes_byte_t m14 [AES_NB];

    genvar g;

    for (g = 0; g < AES_NB; g++) begin : g_mul
        aes_byte_t x2;
        aes_byte_t x4;
        aes_byte_t x8;

        // Byte a0 sits in the top byte of the column word (row 0)
        assign a[g]   = col_in[31-8*g -: 8];
        assign x2     = xtime(a[g]);
        assign x4     = xtime(x2);
        assign x8     = xtime(x4);
        assign m2[g]  = x2;
        assign m3[g]  = x2 ^ a[g];
        assign m9[g]  = x8 ^ a[g];
        assign m11[g] = x8 ^ x2 ^ a[g];
        assign m13[g] = x8 ^ x4 ^ a[g];
        assign m14[g] = x8 ^ x4 ^ x2;
    end

    for (g = 0; g < AES_NB; g++) begin : g_out
        localparam int I1 = (g + 1) % AES_NB;
        localparam int I2 = (g + 2) % AES_NB;
        localparam int I3 = (g + 3) % AES_NB;

        // Circulant matrix row g: forward {2,3,1,1}, inverse {14,11,13,9}
        assign col_out[31-8*g -: 8] = inv ? (m14[g] ^ m11[I1] ^ m13[I2] ^ m9[I3])
                                          : (m2[g]  ^ m3[I1]  ^ a[I2]   ^ a[I3]);
    end

endmodule

// File: rtl/mix_columns_iter.sv
// rtl/mix_columns_iter.sv - iterative column-at-a-time AES (Inv)MixColumns stage with bypass
module mix_columns_iter
    import aes_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_data,
    input  logic                   in_inv,
    input  logic                   in_bypass,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_data
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0] fsm;
    logic [1:0] col;
    logic       inv_q;
    aes_state_t state_q;
    aes_state_t state_mixed;
    aes_col_t   cur_col;
    aes_col_t   mixed_col;
    logic       in_fire;
    logic       out_fire;

    // A finished block may be replaced on the same edge it is consumed, so DONE forwards out_ready
    always_comb begin
        in_ready = 1'b0;
        if (rst_n) begin
            case (fsm)
                ST_IDLE: in_ready = 1'b1;
                ST_DONE: in_ready = out_ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign out_data = state_q;

    // Pick the column currently being worked on
    always_comb begin
        cur_col = state_q[127:96];
        case (col)
            2'd0: cur_col = state_q[127:96];
            2'd1: cur_col = state_q[95:64];
            2'd2: cur_col = state_q[63:32];
            2'd3: cur_col = state_q[31:0];
            default: cur_col = state_q[127:96];
        endcase
    end

    mix_column_word u_mix (
        .col_in  (cur_col),
        .inv     (inv_q),
        .col_out (mixed_col)
    );

    // Splice the mixed column back into its slot, other columns untouched
    always_comb begin
        state_mixed = state_q;
        case (col)
            2'd0: state_mixed[127:96] = mixed_col;
            2'd1: state_mixed[95:64]  = mixed_col;
            2'd2: state_mixed[63:32]  = mixed_col;
            2'd3: state_mixed[31:0]   = mixed_col;
            default: state_mixed = state_q;
        endcase
    end

    // Control FSM, column counter and state register; reset drops any block in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm       <= ST_IDLE;
            col       <= 2'd0;
            inv_q     <= 1'b0;
            state_q   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (fsm)
                ST_IDLE, ST_DONE: begin
                    if (in_fire) begin
                        state_q <= in_data;
                        inv_q   <= in_inv;
                        col     <= 2'd0;
                        if (in_bypass) begin
                            fsm       <= ST_DONE;
                            out_valid <= 1'b1;
                        end else begin
                            fsm       <= ST_BUSY;
                            out_valid <= 1'b0;
                        end
                    end else if (out_fire) begin
                        fsm       <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    state_q <= state_mixed;
                    col     <= col + 2'd1;
                    if (col == 2'd3) begin
                        fsm       <= ST_DONE;
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    fsm       <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_iter.sv
// tb/tb_mix_columns_iter.sv - self-checking bench for mix_columns_iter
module tb_mix_columns_iter;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_inv;
    logic         in_bypass;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    int n_checks;
    int n_fail;

    mix_columns_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_inv    (in_inv),
        .in_bypass (in_bypass),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] din;
        logic         inv;
        logic         byp;
        logic [127:0] exp;
        int           lat;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
        end
        return p;
    endfunction

    // Reference: full-state matrix product over GF(2^8), byte s(r,c) at [127-8*(4c+r)]
    function automatic logic [127:0] model(input logic [127:0] din, input logic inv, input logic byp);
        logic [7:0]   cf [4];
        logic [7:0]   acc;
        logic [127:0] res;
        if (byp) return din;
        if (inv) begin
            cf[0] = 8'd14; cf[1] = 8'd11; cf[2] = 8'd13; cf[3] = 8'd9;
        end else begin
            cf[0] = 8'd2;  cf[1] = 8'd3;  cf[2] = 8'd1;  cf[3] = 8'd1;
        end
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    acc = acc ^ gmul(cf[(j - r + 4) % 4], din[127-8*(4*c+j) -: 8]);
                end
                res[127-8*(4*c+r) -: 8] = acc;
            end
        end
        return res;
    endfunction

    task automatic run_block(input logic [127:0] din, input logic inv, input logic byp,
                             output logic [127:0] res, output int lat);
        int guard;
        in_data   = din;
        in_inv    = inv;
        in_bypass = byp;
        in_valid  = 1'b1;
        guard = 0;
        while (!in_ready && guard < 20) begin
            tick();
            guard++;
        end
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        res = out_data;
        tick();
    endtask

    vec_t         vecs [6];
    logic [127:0] res;
    int           lat;
    logic [127:0] blk [6];
    logic [127:0] held;
    logic [127:0] bp_b;
    int           stable_err;
    int           ready_err;

    logic [127:0] exp_q [$];
    logic [127:0] exp_v;
    int           sent;
    int           recv;
    int           cyc;
    logic         accepted;
    logic         prev_stall;
    logic [127:0] prev_data;
    localparam int N_RAND = 1000;

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_inv    = 1'b0;
        in_bypass = 1'b0;
        out_ready = 1'b1;

        vecs[0] = '{128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 1'b0,
                    128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 4};
        vecs[1] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1, 1'b0,
                    128'hdb135345_f20a225c_01010101_c6c6c6c6, 4};
        vecs[2] = '{128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5, 1'b0, 1'b0,
                    128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6, 4};
        vecs[3] = '{128'hd5d5d7d6_d5d5d7d6_d5d5d7d6_d5d5d7d6, 1'b1, 1'b0,
                    128'hd4d4d4d5_d4d4d4d5_d4d4d4d5_d4d4d4d5, 4};
        vecs[4] = '{128'h00112233_44556677_8899aabb_ccddeeff, 1'b0, 1'b1,
                    128'h00112233_44556677_8899aabb_ccddeeff, 0};
        vecs[5] = '{128'h00112233_44556677_8899aabb_ccddeeff, 1'b1, 1'b1,
                    128'h00112233_44556677_8899aabb_ccddeeff, 0};

        // Reset state
        tick();
        tick();
        check("reset_in_ready",  {127'd0, in_ready},  128'd0);
        check("reset_out_valid", {127'd0, out_valid}, 128'd0);
        check("reset_out_data",  out_data,            128'd0);
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", {127'd0, in_ready}, 128'd1);
        tick();

        // Known-answer vectors; latency counts ticks after the transfer edge
        for (int i = 0; i < 6; i++) begin
            run_block(vecs[i].din, vecs[i].inv, vecs[i].byp, res, lat);
            check($sformatf("vec%0d_data", i), res, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 128'(lat), 128'(vecs[i].lat));
            check($sformatf("vec%0d_consumed", i), {127'd0, out_valid}, 128'd0);
        end

        // Back-to-back bypass blocks at one per cycle
        for (int i = 0; i < 6; i++) blk[i] = {$urandom, $urandom, $urandom, $urandom};
        in_bypass = 1'b1;
        in_inv    = 1'b0;
        in_valid  = 1'b1;
        in_data   = blk[0];
        tick();
        for (int i = 1; i < 6; i++) begin
            check($sformatf("burst%0d_valid", i), {127'd0, out_valid && in_ready}, 128'd1);
            check($sformatf("burst%0d_data", i), out_data, blk[i-1]);
            in_data = blk[i];
            tick();
        end
        in_valid = 1'b0;
        check("burst_last_data", out_data, blk[5]);
        tick();
        check("burst_drained", {127'd0, out_valid}, 128'd0);

        // Backpressure in DONE, then simultaneous out/in transfer
        out_ready = 1'b0;
        in_bypass = 1'b0;
        in_inv    = 1'b0;
        in_data   = {$urandom, $urandom, $urandom, $urandom};
        exp_v     = model(in_data, 1'b0, 1'b0);
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("bp_first_data", out_data, exp_v);
        held = out_data;
        stable_err = 0;
        ready_err  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_data !== held || out_valid !== 1'b1) stable_err++;
            if (in_ready !== 1'b0) ready_err++;
        end
        check("bp_data_stable", 128'(stable_err), 128'd0);
        check("bp_in_ready_low", 128'(ready_err), 128'd0);
        bp_b      = {$urandom, $urandom, $urandom, $urandom};
        in_data   = bp_b;
        in_inv    = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_follows", {127'd0, in_ready}, 128'd1);
        tick();
        in_valid = 1'b0;
        check("bp_swap_valid_low", {127'd0, out_valid}, 128'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("bp_swap_latency", 128'(lat), 128'd4);
        check("bp_swap_data", out_data, model(bp_b, 1'b1, 1'b0));
        tick();

        // Reset while col=2 discards the block
        in_data   = {$urandom, $urandom, $urandom, $urandom};
        in_inv    = 1'b0;
        in_bypass = 1'b0;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst_out_valid", {127'd0, out_valid}, 128'd0);
        check("midrst_out_data",  out_data,            128'd0);
        check("midrst_in_ready",  {127'd0, in_ready},  128'd0);
        rst_n = 1'b1;
        bp_b = {$urandom, $urandom, $urandom, $urandom};
        run_block(bp_b, 1'b0, 1'b0, res, lat);
        check("postrst_data", res, model(bp_b, 1'b0, 1'b0));
        check("postrst_latency", 128'(lat), 128'd4);

        // Random traffic against the reference model with random stalls
        sent       = 0;
        recv       = 0;
        cyc        = 0;
        accepted   = 1'b0;
        prev_stall = 1'b0;
        prev_data  = '0;
        in_valid   = 1'b0;
        while ((sent < N_RAND || exp_q.size() != 0) && cyc < 40000) begin
            if (accepted) in_valid = 1'b0;
            accepted  = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
            if (!in_valid && sent < N_RAND && $urandom_range(0, 3) != 0) begin
                in_data   = {$urandom, $urandom, $urandom, $urandom};
                in_inv    = 1'($urandom_range(0, 1));
                in_bypass = ($urandom_range(0, 2) == 0);
                in_valid  = 1'b1;
            end
            #1;
            if (prev_stall) begin
                check("rand_stall_hold", {out_valid, out_data}, {1'b1, prev_data});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected_output", out_data, 128'd0);
                    n_fail += (out_data === 128'd0) ? 1 : 0;
                end else begin
                    exp_v = exp_q.pop_front();
                    check($sformatf("rand_out%0d", recv), out_data, exp_v);
                end
                recv++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (in_valid && in_ready) begin
                exp_q.push_back(model(in_data, in_inv, in_bypass));
                sent++;
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        check("rand_not_timed_out", 128'(cyc < 40000), 128'd1);
        check("rand_recv_count", 128'(recv), 128'(N_RAND));
        check("rand_queue_empty", 128'(exp_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
